// File: rtl/dpram_pkg.sv
// dpram_pkg: shared constants and types for the dual-port RAM copy engine.
//   DPRAM_DATA_W / DPRAM_ADDR_W : default RAM word and address widths (64x8)
//   LEN_W                       : width of a word count 0..2^ADDR_W
//   copy_state_t                : copy FSM state encoding
package dpram_pkg;

  localparam int DPRAM_DATA_W = 8;
  localparam int DPRAM_ADDR_W = 6;
  localparam int LEN_W        = DPRAM_ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } copy_state_t;

endpackage

// File: rtl/dpram_copy_engine_if.sv
// dpram_copy_engine_if: both ports of the dual-port RAM as seen by the engine.
//   addr_a/we_a/data_a : port A address / write enable / write data
//   q_a                : port A registered read data (valid one cycle after addr_a)
//   addr_b/we_b/data_b : port B address / write enable / write data
// Modports: master = copy engine, slave = RAM.
//
// Handshake semantics: the RAM ports carry no valid/ready pair. A write
// lands on every rising edge where we_b=1, and q_a always reflects the
// addr_a presented one cycle earlier. On the control side, start is a
// request qualified only by the engine not being mid-copy (busy=0); there
// is no ready, and a start seen while busy is dropped.
interface dpram_copy_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) ();

  logic [ADDR_W-1:0] addr_a;
  logic              we_a;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] q_a;
  logic [ADDR_W-1:0] addr_b;
  logic              we_b;
  logic [DATA_W-1:0] data_b;

  modport master (
    output addr_a, we_a, data_a, addr_b, we_b, data_b,
    input  q_a
  );

  modport slave (
    input  addr_a, we_a, data_a, addr_b, we_b, data_b,
    output q_a
  );

endinterface

// File: rtl/dpram_copy_engine_copy_addr_ctr.sv
// copy_addr_ctr: loadable wrapping address counter with a remaining count.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_addr / load_cnt (takes priority over en)
//   en         : advance address by one (wraps mod 2^ADDR_W), count down
//   addr       : current address (registered)
//   last       : current address is the final one of the run
module copy_addr_ctr #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W:0]   load_cnt,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int LW = ADDR_W + 1;

  // Words still to be presented, including the one on addr right now.
  logic [ADDR_W:0] remaining;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_cnt;
    end else if (en) begin
      addr      <= addr + ADDR_W'(1);
      remaining <= remaining - LW'(1);
    end
  end

  assign last = (remaining == LW'(1));

endmodule

// File: rtl/dpram_copy_engine.sv
// dpram_copy_engine: block copy RAM[src..src+len-1] -> RAM[dst..dst+len-1],
// reading through port A and writing through port B, one word per clock.
//   clk, rst_n         : clock, synchronous active-low reset
//   start              : copy request, taken only when not mid-copy
//   src_addr, dst_addr : first source / destination word address
//   len                : word count 0..2^ADDR_W
//   busy, done         : copy in progress / one-cycle completion pulse
//   state_dbg          : current FSM state
//   checksum           : sum of written words (only with COPY_CHECKSUM_EN)
//   ram                : RAM port bundle (master side)
// Optional feature macro: COPY_CHECKSUM_EN adds the checksum output.
module dpram_copy_engine
  import dpram_pkg::*;
#(
  parameter int DATA_W = DPRAM_DATA_W,
  parameter int ADDR_W = DPRAM_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     len,
  output logic                busy,
  output logic                done,
  output copy_state_t         state_dbg,
`ifdef COPY_CHECKSUM_EN
  output logic [DATA_W-1:0]   checksum,
`endif
  dpram_copy_engine_if.master ram
);

  copy_state_t       state;
  logic [ADDR_W-1:0] delta;     // dst - src, so the write address trails the read address
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_last;
  logic              accept;
  logic              ctr_load;
  logic              ctr_en;

  // DONE is the final cycle of a copy and the FSM is IDLE at the next edge,
  // so a start in DONE is taken just like one in IDLE (back-to-back copies).
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign ctr_load = accept && (len != '0);
  assign ctr_en   = (state == READ) && !rd_last;

  copy_addr_ctr #(.ADDR_W(ADDR_W)) u_rd_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ctr_load),
    .load_addr (src_addr),
    .load_cnt  (len),
    .en        (ctr_en),
    .addr      (rd_addr),
    .last      (rd_last)
  );

  assign ram.addr_a = rd_addr;
  assign ram.we_a   = 1'b0;
  assign ram.data_a = '0;
  assign ram.data_b = ram.q_a;
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      delta      <= '0;
      ram.we_b   <= 1'b0;
      ram.addr_b <= '0;
    end else begin
      // Write side is the read side delayed one cycle: the read issued in a
      // READ cycle returns its data while the matching write is presented.
      ram.we_b <= (state == READ);
      if (state == READ) begin
        ram.addr_b <= rd_addr + delta;
      end
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            delta <= dst_addr - src_addr;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        READ: begin
          if (rd_last) state <= DRAIN;
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COPY_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (ram.we_b) begin
      checksum <= checksum + ram.data_b;
    end
  end
`endif

endmodule
